rv32i_regfile_arbiter: RTL and testbench

//  Front-end for the rv32i_registers file: arbitrates its single write port between execute

---
 rtl/rv32i_regfile_arbiter.sv | 141 ++++++++++++++
 tb/tb_rv32i_regfile_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile_arbiter.sv
// Register-file front end: round-robin arbitration of the single write port between
// execute (A) and load (B) writeback, plus a valid/ready read sequencer with write bypass.
module rv32i_regfile_arbiter #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wa_valid_i,
  output logic                wa_ready_o,
  input  logic [REG_BITS-1:0] wa_addr_i,
  input  logic [XLEN-1:0]     wa_data_i,
  input  logic                wb_valid_i,
  output logic                wb_ready_o,
  input  logic [REG_BITS-1:0] wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                rq_valid_i,
  output logic                rq_ready_o,
  input  logic [REG_BITS-1:0] rq_rs1_i,
  input  logic [REG_BITS-1:0] rq_rs2_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [XLEN-1:0]     rsp_rs1_o,
  output logic [XLEN-1:0]     rsp_rs2_o,
  output logic                rf_write_o,
  output logic [REG_BITS-1:0] rf_rd_addr_o,
  output logic [XLEN-1:0]     rf_data_o,
  output logic [REG_BITS-1:0] rf_rs1_addr_o,
  output logic [REG_BITS-1:0] rf_rs2_addr_o,
  input  logic [XLEN-1:0]     rf_rs1_i,
  input  logic [XLEN-1:0]     rf_rs2_i
);

  typedef enum logic [1:0] {IDLE, RSP, HOLD} state_e;
  typedef enum logic {SRC_A, SRC_B} src_e;

  state_e              state_q, state_d;
  src_e                rr_last_q, rr_last_d;
  logic [REG_BITS-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  logic                byp1_q, byp1_d, byp2_q, byp2_d;
  logic [XLEN-1:0]     byp_data_q, byp_data_d;
  logic [XLEN-1:0]     hold1_q, hold1_d, hold2_q, hold2_d;

  logic a_req, b_req, grant_a, grant_b, wr_grant, accept;

  // Write arbitration: x0 requests are acknowledged but never reach the regfile.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rr_last_d    = rr_last_q;
    rf_rd_addr_o = '0;
    rf_data_o    = '0;
    a_req        = wa_valid_i && (wa_addr_i != '0);
    b_req        = wb_valid_i && (wb_addr_i != '0);
    grant_a      = a_req && (!b_req || rr_last_q == SRC_B);
    grant_b      = b_req && (!a_req || rr_last_q == SRC_A);
    wr_grant     = grant_a || grant_b;
    if (grant_a) begin
      rf_rd_addr_o = wa_addr_i;
      rf_data_o    = wa_data_i;
    end else if (grant_b) begin
      rf_rd_addr_o = wb_addr_i;
      rf_data_o    = wb_data_i;
    end
    if (a_req && b_req) rr_last_d = grant_a ? SRC_A : SRC_B;
  end

  assign wa_ready_o = (wa_valid_i && wa_addr_i == '0) || grant_a;
  assign wb_ready_o = (wb_valid_i && wb_addr_i == '0) || grant_b;
  assign rf_write_o = wr_grant && !rst_i;

  // Read sequencer
  assign rq_ready_o    = (state_q == IDLE) || (state_q != IDLE && rsp_ready_i);
  assign accept        = rq_valid_i && rq_ready_o;
  assign rf_rs1_addr_o = rq_ready_o ? rq_rs1_i : rs1_addr_q;
  assign rf_rs2_addr_o = rq_ready_o ? rq_rs2_i : rs2_addr_q;
  assign rsp_valid_o   = (state_q != IDLE);

  always_comb begin
    rsp_rs1_o = '0;
    rsp_rs2_o = '0;
    if (state_q == RSP) begin
      rsp_rs1_o = byp1_q ? byp_data_q : rf_rs1_i;
      rsp_rs2_o = byp2_q ? byp_data_q : rf_rs2_i;
    end else if (state_q == HOLD) begin
      rsp_rs1_o = hold1_q;
      rsp_rs2_o = hold2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    byp_data_d = byp_data_q;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    if (accept) begin
      // The regfile returns old data on a same-edge write, so remember the write instead.
      state_d    = RSP;
      rs1_addr_d = rq_rs1_i;
      rs2_addr_d = rq_rs2_i;
      byp1_d     = wr_grant && (rf_rd_addr_o == rq_rs1_i);
      byp2_d     = wr_grant && (rf_rd_addr_o == rq_rs2_i);
      byp_data_d = rf_data_o;
    end else if (state_q != IDLE && rsp_ready_i) begin
      state_d = IDLE;
    end else if (state_q == RSP) begin
      state_d = HOLD;
      hold1_d = rsp_rs1_o;
      hold2_d = rsp_rs2_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_last_q  <= SRC_B;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
      hold1_q    <= '0;
      hold2_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_data_q <= byp_data_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
    end
  end

endmodule

// File: tb/tb_rv32i_regfile_arbiter.sv
// Directed bench for rv32i_regfile_arbiter with a behavioural 1-cycle-latency regfile
// (read-during-write returns old data).
module tb_rv32i_regfile_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wa_valid, wa_ready, wb_valid, wb_ready;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic        rq_valid, rq_ready, rsp_valid, rsp_ready;
  logic [4:0]  rq_rs1, rq_rs2;
  logic [31:0] rsp_rs1, rsp_rs2;
  logic        rf_write;
  logic [4:0]  rf_rd_addr, rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_data, rf_rs1, rf_rs2;

  logic [31:0] mem [32] = '{default: '0};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write && rf_rd_addr != 5'd0) mem[rf_rd_addr] <= rf_data;
    rf_rs1 <= mem[rf_rs1_addr];
    rf_rs2 <= mem[rf_rs2_addr];
  end

  rv32i_regfile_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .wa_valid_i(wa_valid), .wa_ready_o(wa_ready), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rq_valid_i(rq_valid), .rq_ready_o(rq_ready), .rq_rs1_i(rq_rs1), .rq_rs2_i(rq_rs2),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rs1_o(rsp_rs1), .rsp_rs2_o(rsp_rs2),
    .rf_write_o(rf_write), .rf_rd_addr_o(rf_rd_addr), .rf_data_o(rf_data),
    .rf_rs1_addr_o(rf_rs1_addr), .rf_rs2_addr_o(rf_rs2_addr),
    .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wa(input logic v, input logic [4:0] a, input logic [31:0] d);
    wa_valid = v; wa_addr = a; wa_data = d;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  task automatic set_rq(input logic v, input logic [4:0] r1, input logic [4:0] r2);
    rq_valid = v; rq_rs1 = r1; rq_rs2 = r2;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_wa(1'b1, 5'd5, 32'h1234);
    set_wb(1'b0, 5'd0, 32'h0);
    set_rq(1'b0, 5'd0, 5'd0);
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rf_write",  rf_write, 0);
    check("rst_rsp_rs1",   rsp_rs1, 0);
    @(negedge clk) rst = 1'b0;

    // 1) write x5 then read x5/x0
    #1;
    check("t1_wa_ready", wa_ready, 1);
    check("t1_rf_write", rf_write, 1);
    check("t1_rd_addr",  rf_rd_addr, 5);
    tick();
    set_wa(1'b0, 5'd0, 32'h0);
    set_rq(1'b1, 5'd5, 5'd0);
    #1 check("t1_rq_ready", rq_ready, 1);
    tick();
    set_rq(1'b0, 5'd0, 5'd0);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_rs1",   rsp_rs1, 32'h1234);
    check("t1_rsp_rs2",   rsp_rs2, 0);
    tick();
    check("t1_idle", rsp_valid, 0);

    // 2) contention alternates A, B, A, B
    set_wa(1'b1, 5'd3, 32'hAAAA);
    set_wb(1'b1, 5'd4, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_wa_ready", wa_ready, (i % 2 == 0) ? 1 : 0);
      check("t2_wb_ready", wb_ready, (i % 2 == 1) ? 1 : 0);
      check("t2_rd_addr",  rf_rd_addr, (i % 2 == 0) ? 3 : 4);
      check("t2_data",     rf_data, (i % 2 == 0) ? 32'hAAAA : 32'hBBBB);
      tick();
    end

    // 3) A to x0 alongside B x7: both ready, only x7 written
    set_wa(1'b1, 5'd0, 32'h5555);
    set_wb(1'b1, 5'd7, 32'h77);
    #1;
    check("t3_wa_ready", wa_ready, 1);
    check("t3_wb_ready", wb_ready, 1);
    check("t3_rf_write", rf_write, 1);
    check("t3_rd_addr",  rf_rd_addr, 7);
    check("t3_data",     rf_data, 32'h77);
    tick();
    set_wa(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    #1 check("t3_no_write", rf_write, 0);

    // 4) read x9 on the same edge as a write to x9
    set_wa(1'b1, 5'd9, 32'h1111);
    tick();
    set_wa(1'b1, 5'd9, 32'hDEAD);
    set_rq(1'b1, 5'd9, 5'd7);
    tick();
    set_wa(1'b0, 5'd0, 32'h0);
    set_rq(1'b0, 5'd0, 5'd0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_bypass",    rsp_rs1, 32'hDEAD);
    check("t4_rs2",       rsp_rs2, 32'h77);

    // 5) stall 3 cycles while x9 is rewritten, then back-to-back reads
    rsp_ready = 1'b0;
    set_rq(1'b1, 5'd3, 5'd4);
    set_wb(1'b1, 5'd9, 32'hBEEF);
    #1 check("t5_rq_stall", rq_ready, 0);
    tick();
    set_wb(1'b1, 5'd9, 32'hC0DE);
    check("t5_hold_valid", rsp_valid, 1);
    check("t5_hold_rs1a",  rsp_rs1, 32'hDEAD);
    check("t5_addr_held",  rf_rs1_addr, 9);
    check("t5_rq_hold",    rq_ready, 0);
    tick();
    set_wb(1'b1, 5'd9, 32'hF00D);
    check("t5_hold_rs1b", rsp_rs1, 32'hDEAD);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check("t5_hold_rs1c", rsp_rs1, 32'hDEAD);
    check("t5_hold_rs2",  rsp_rs2, 32'h77);
    rsp_ready = 1'b1;
    #1 check("t5_rq_release", rq_ready, 1);
    tick();
    set_rq(1'b1, 5'd9, 5'd5);
    check("t5_b2b1_valid", rsp_valid, 1);
    check("t5_b2b1_rs1",   rsp_rs1, 32'hAAAA);
    check("t5_b2b1_rs2",   rsp_rs2, 32'hBBBB);
    tick();
    set_rq(1'b0, 5'd0, 5'd0);
    check("t5_b2b2_valid", rsp_valid, 1);
    check("t5_b2b2_rs1",   rsp_rs1, 32'hF00D);
    check("t5_b2b2_rs2",   rsp_rs2, 32'h1234);
    tick();
    check("t5_idle", rsp_valid, 0);

    // 6) reset while holding a response
    set_wa(1'b1, 5'd3, 32'h3333);
    set_wb(1'b1, 5'd4, 32'h4444);
    #1 check("t6_pre_grant_a", wa_ready, 1);
    tick();
    set_wa(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_rq(1'b1, 5'd5, 5'd3);
    tick();
    set_rq(1'b0, 5'd0, 5'd0);
    rsp_ready = 1'b0;
    tick();
    check("t6_hold_valid", rsp_valid, 1);
    check("t6_hold_rs1",   rsp_rs1, 32'h1234);
    check("t6_hold_rs2",   rsp_rs2, 32'h3333);
    set_wa(1'b1, 5'd3, 32'h1);
    set_wb(1'b1, 5'd4, 32'h2);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", rsp_valid, 0);
    check("t6_rst_write", rf_write, 0);
    @(negedge clk) rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("t6_grant_a",  wa_ready, 1);
    check("t6_wb_wait",  wb_ready, 0);
    check("t6_rd_addr",  rf_rd_addr, 3);
    tick();
    set_wa(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    check("t6_idle", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
